// File: rtl/iic_cfg_pkg.sv
// Shared types, op flags and the default register table for the IIC configuration sequencer.
package iic_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_CHECK,
      ST_GAP,
      ST_FINISH
   } cfg_state_e;

   typedef struct packed {
      logic [15:0] reg_addr;
      logic [7:0]  data;
   } cfg_entry_t;

   localparam logic IIC_WR = 1'b0;
   localparam logic IIC_RD = 1'b1;

   localparam int CFG_TABLE_LEN = 8;
   localparam int CFG_IDX_W     = 3;

   localparam cfg_entry_t CFG_TABLE [CFG_TABLE_LEN] = '{
      '{16'h3008, 8'h82},
      '{16'h3103, 8'h03},
      '{16'h3017, 8'hFF},
      '{16'h3018, 8'hFF},
      '{16'h3037, 8'h13},
      '{16'h3108, 8'h01},
      '{16'h3630, 8'h36},
      '{16'h3631, 8'h0E}
   };

endpackage

// File: rtl/iic_cfg_rom.sv
// Combinational index-to-entry lookup into the package register table.
module iic_cfg_rom
   import iic_cfg_pkg::*;
(
   input  logic [7:0] i_idx,
   output cfg_entry_t o_entry
);

   // Indices past the end of the table read back as an all-zero entry.
   always_comb begin
      o_entry = '0;
      if (i_idx < 8'(CFG_TABLE_LEN)) begin
         o_entry = CFG_TABLE[i_idx[CFG_IDX_W-1:0]];
      end
   end

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Table-driven IIC register-write sequencer feeding iic_drive, with bounded retries.
// Define IIC_READBACK_VERIFY_EN to read back and compare every entry after its write.
module iic_cfg_sequencer
   import iic_cfg_pkg::*;
#(
   parameter int         NUM_REGS    = 8,
   parameter logic [7:0] DEV_ADDR    = 8'h78,
   parameter int         MAX_RETRY   = 3,
   parameter int         ACK_TIMEOUT = 16,
   parameter int         GAP_CYCLES  = 4
)
(
   input  logic        clk_i,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic        busy,
   input  logic        err,
   input  logic [7:0]  rd_data,
   output logic        start_en,
   output logic        wr_rd_flag,
   output logic [7:0]  i2c_device_addr,
   output logic [15:0] register,
   output logic [7:0]  data_byte,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_fail,
   output logic [7:0]  fail_idx
);

   localparam logic [7:0]  LAST_IDX  = 8'(NUM_REGS - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
   localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

   cfg_state_e  r_state, w_state_nxt;
   logic [7:0]  r_idx, w_idx_nxt;
   logic [3:0]  r_retry, w_retry_nxt;
   logic        r_op, w_op_nxt;
   logic [15:0] r_timer;
   logic        r_err_lat;
   logic        w_fail_attempt;
   logic        w_abort;
   cfg_entry_t  w_entry;

   logic        r_start_en, r_wr_rd, r_cfg_busy, r_cfg_done, r_cfg_fail;
   logic [15:0] r_register;
   logic [7:0]  r_data_byte, r_fail_idx;

`ifdef IIC_READBACK_VERIFY_EN
   logic [7:0]  r_rd_lat;
   logic [7:0]  r_exp_data;
`else
   logic        w_unused_rd;
   assign w_unused_rd = ^rd_data;
`endif

   // Addressed with the next index so the command registers load the right entry on ISSUE entry.
   iic_cfg_rom u_rom (
      .i_idx   (w_idx_nxt),
      .o_entry (w_entry)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_retry_nxt = r_retry;
      w_op_nxt    = r_op;
      w_abort     = 1'b0;
`ifdef IIC_READBACK_VERIFY_EN
      w_fail_attempt = r_err_lat || ((r_op == IIC_RD) && (r_rd_lat != r_exp_data));
`else
      w_fail_attempt = r_err_lat;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (cfg_start) begin
               w_idx_nxt   = 8'd0;
               w_retry_nxt = 4'd0;
               w_op_nxt    = IIC_WR;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (busy)                        w_state_nxt = ST_WAIT_DONE;
            else if (r_timer == ACK_LAST)    w_state_nxt = ST_CHECK;
         end
         ST_WAIT_DONE: begin
            if (!busy) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_fail_attempt) begin
               if (r_retry < RETRY_MAX) begin
                  w_retry_nxt = r_retry + 4'd1;
                  w_op_nxt    = IIC_WR;
                  w_state_nxt = ST_GAP;
               end else begin
                  w_abort     = 1'b1;
                  w_state_nxt = ST_FINISH;
               end
            end else begin
`ifdef IIC_READBACK_VERIFY_EN
               if (r_op == IIC_WR) begin
                  w_op_nxt    = IIC_RD;
                  w_state_nxt = ST_GAP;
               end else
`endif
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_idx_nxt   = r_idx + 8'd1;
                  w_retry_nxt = 4'd0;
                  w_op_nxt    = IIC_WR;
                  w_state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (r_timer == GAP_LAST) w_state_nxt = ST_ISSUE;
         end
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= 8'd0;
         r_retry     <= 4'd0;
         r_op        <= IIC_WR;
         r_timer     <= 16'd0;
         r_err_lat   <= 1'b0;
         r_start_en  <= 1'b0;
         r_wr_rd     <= IIC_WR;
         r_register  <= 16'd0;
         r_data_byte <= 8'd0;
         r_cfg_busy  <= 1'b0;
         r_cfg_done  <= 1'b0;
         r_cfg_fail  <= 1'b0;
         r_fail_idx  <= 8'd0;
`ifdef IIC_READBACK_VERIFY_EN
         r_rd_lat    <= 8'd0;
         r_exp_data  <= 8'd0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_retry    <= w_retry_nxt;
         r_op       <= w_op_nxt;
         r_timer    <= (w_state_nxt != r_state) ? 16'd0 : r_timer + 16'd1;
         r_start_en <= (w_state_nxt == ST_ISSUE);
         r_cfg_busy <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FINISH);
         r_cfg_done <= (w_state_nxt == ST_FINISH);

         if ((r_state == ST_IDLE) && cfg_start) begin
            r_cfg_fail <= 1'b0;
            r_fail_idx <= 8'd0;
         end
         if (w_abort) begin
            r_cfg_fail <= 1'b1;
            r_fail_idx <= r_idx;
         end

         // Command outputs only move when a transaction is launched.
         if (w_state_nxt == ST_ISSUE) begin
            r_wr_rd     <= w_op_nxt;
            r_register  <= w_entry.reg_addr;
            r_data_byte <= (w_op_nxt == IIC_RD) ? 8'h00 : w_entry.data;
`ifdef IIC_READBACK_VERIFY_EN
            r_exp_data  <= w_entry.data;
`endif
         end

         if ((r_state == ST_WAIT_ACK) && !busy && (r_timer == ACK_LAST)) begin
            r_err_lat <= 1'b1;
         end
         if ((r_state == ST_WAIT_DONE) && !busy) begin
            r_err_lat <= err;
`ifdef IIC_READBACK_VERIFY_EN
            r_rd_lat  <= rd_data;
`endif
         end
      end
   end

   assign start_en        = r_start_en;
   assign wr_rd_flag      = r_wr_rd;
   assign i2c_device_addr = DEV_ADDR;
   assign register        = r_register;
   assign data_byte       = r_data_byte;
   assign cfg_busy        = r_cfg_busy;
   assign cfg_done        = r_cfg_done;
   assign cfg_fail        = r_cfg_fail;
   assign fail_idx        = r_fail_idx;

endmodule

// File: doc/iic_cfg_sequencer.md
# iic_cfg_sequencer

Table-driven command sequencer that sits directly upstream of `iic_drive` in the IIC configuration path and feeds its start/command handshake. On a start request it walks a fixed register table, issuing one write per entry. It optionally reads each entry back and compares the value. Failed transactions are retried a bounded number of times, and the block reports overall completion and the first failing entry.

## Interface
- `NUM_REGS`, 8: number of table entries, 1..256.
- `DEV_ADDR`, 8'h78: value driven on `i2c_device_addr`.
- `MAX_RETRY`, 3: retries allowed per entry after the first attempt, 0..15.
- `ACK_TIMEOUT`, 16: `clk_i` cycles to wait for `busy` to rise after `start_en`.
- `GAP_CYCLES`, 4: idle cycles between consecutive transactions, at least 1.
- `clk_i`  in  1  sole clock, the divided IIC state clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_start`  in  1  one-cycle request to run the table.
- `busy`  in  1  from `iic_drive`; high while a transaction runs.
- `err`  in  1  from `iic_drive`; NACK or bus error, valid when `busy` falls.
- `rd_data`  in  8  from `iic_drive`; read byte, valid when `busy` falls.
- `start_en`  out  1  one-cycle transaction launch to `iic_drive`.
- `wr_rd_flag`  out  1  0 = write, 1 = read.
- `i2c_device_addr`  out  8  device address.
- `register`  out  16  register address of the current entry.
- `data_byte`  out  8  write data of the current entry.
- `cfg_busy`  out  1  high from the accepted `cfg_start` until `cfg_done`.
- `cfg_done`  out  1  one-cycle pulse at the end of a run.
- `cfg_fail`  out  1  run aborted; held until the next accepted `cfg_start`.
- `fail_idx`  out  8  index of the failing entry; valid while `cfg_fail`=1.

## Operation
- States are IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CHECK, GAP and FINISH.
- IDLE: when `cfg_start`=1, the block does the following:
  - index is set to 0 and the retry count to 0;
  - op is set to write;
  - `cfg_fail` is cleared;
  - the state moves to ISSUE.
- IDLE: `cfg_start` is ignored in every other state.
- ISSUE: drives `start_en`=1 for exactly one cycle, then moves to WAIT_ACK.
- WAIT_ACK: waits for `busy`=1, then moves to WAIT_DONE.
- WAIT_ACK: after `ACK_TIMEOUT` cycles without `busy`, the attempt is treated as a failure and the state moves to CHECK.
- WAIT_DONE: on the first cycle with `busy`=0, the block latches `err` and `rd_data` and moves to CHECK.
- CHECK, attempt failed (`err`=1, timeout, or readback mismatch):
  - if retry count < `MAX_RETRY`, the retry count increments, op restarts at write, and the state moves to GAP;
  - otherwise `cfg_fail`=1, `fail_idx`=index, and the state moves to FINISH.
- CHECK, attempt succeeded:
  - write with verify compiled in: op becomes read and the state moves to GAP;
  - otherwise, if index = `NUM_REGS`-1, the state moves to FINISH;
  - otherwise index increments, the retry count clears, op becomes write, and the state moves to GAP.
- GAP: counts `GAP_CYCLES` cycles, then moves to ISSUE.
- FINISH: pulses `cfg_done` for one cycle, drops `cfg_busy`, and returns to IDLE.
- Command outputs (`wr_rd_flag`, `register`, `data_byte`) are registered. They change only on entry to ISSUE and are stable through WAIT_DONE.
- `i2c_device_addr` is always `DEV_ADDR`.
- Read transactions drive `data_byte`=8'h00.

## Timing
- Reset values: `start_en`=0, `wr_rd_flag`=0, `i2c_device_addr`=`DEV_ADDR`, `register`=0, `data_byte`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_fail`=0, `fail_idx`=0. The state is IDLE.
- `rst` in any state aborts immediately. `start_en` is never left high.
- `cfg_start` at cycle N gives `cfg_busy`=1 at N+1 and `start_en`=1 at N+1.
- Minimum cost per transaction is 1 (ISSUE) + 1 + drive duration + 1 (CHECK) + `GAP_CYCLES`.
- `busy` already high in ISSUE is a protocol error by the drive. It is handled as a normal acknowledge on the next cycle.
- `cfg_done` and `cfg_busy` falling occur in the same cycle.
- `cfg_fail` and `fail_idx` are valid in that same cycle.
- With `MAX_RETRY`=0, one failed attempt aborts the run.

## Configuration
- `IIC_READBACK_VERIFY_EN` defined: after every successful write, the same register is read. `rd_data` must equal the table data, otherwise the attempt fails. A retry restarts with the write.
- `IIC_READBACK_VERIFY_EN` undefined: writes only. `wr_rd_flag` is constant 0 and the compare logic is absent.

## Structure
- Package `iic_cfg_pkg` holds:
  - the state enum;
  - the entry typedef {reg 16b, data 8b};
  - the `IIC_WR`/`IIC_RD` flag constants;
  - the default table contents.
- Sub-module `iic_cfg_rom` provides a combinational index → entry lookup from the package table.

## Test plan
- Drive model ACKs all, 3 entries ({0x3008,0x82},{0x3103,0x03},{0x3017,0xFF}), verify off → exactly 3 `start_en` pulses, all with `wr_rd_flag`=0 and matching reg/data, then `cfg_done`=1 and `cfg_fail`=0.
- Verify on, model returns written data → 6 transactions alternating write/read per entry, then `cfg_done`=1 and `cfg_fail`=0.
- Model asserts `err` on the first two attempts at entry 1, `MAX_RETRY`=3 → entry 1 is issued 3 times and the run passes.
- Model always NACKs entry 2, `MAX_RETRY`=3 → 4 attempts at entry 2, then `cfg_fail`=1, `fail_idx`=2 and `cfg_done` pulses.
- Model never raises `busy` → after `ACK_TIMEOUT` cycles a retry occurs. After `MAX_RETRY`+1 attempts, `cfg_fail`=1 and `fail_idx`=0.
- `rst` asserted in WAIT_DONE and `cfg_start` pulsed while busy → all outputs return to reset values. The mid-run `cfg_start` is ignored, with no extra run.
